mult_sequencer: RTL and testbench

Control and handshake stage placed directly upstream of the 4-bit shift-add multiplier datapath. It accepts operand pairs over a valid/ready interface and registers them. It then sequences the datapath with one load pulse followed by WIDTH add/shift pulses, captures the 2·WIDTH-bit product from the datapath HI/LO registers, and holds the result on a valid/ready output until it is consumed.

---
 rtl/mult_seq_pkg.sv | 21 ++
 rtl/iter_counter.sv | 30 +++
 rtl/mult_sequencer.sv | 85 ++++++++
 tb/tb_mult_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared definitions for the shift-add multiplier sequencer.
//   state_t    - sequencer FSM states
//   DEF_WIDTH  - default operand width
//   cnt_width  - width of an iteration counter able to hold 0..w
package mult_seq_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      CAPTURE,
      HOLD
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/iter_counter.sv
// iter_counter: iteration counter for the multiplier sequencer.
//   clock  - rising-edge clock
//   reset  - synchronous, active-high
//   clear  - force count to 0 (has priority over enable)
//   enable - increment count
//   last   - count has reached WIDTH-1 (final iteration)
module iter_counter
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int CW = cnt_width(WIDTH);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) count <= '0;
      else if (enable)    count <= count + 1'b1;
   end

   assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: control/handshake stage in front of a shift-add multiplier
// datapath. Accepts an operand pair, issues one init pulse and WIDTH shift
// pulses, captures {HI,LO} and holds the product until consumed.
//   clock, reset                  - clock, synchronous active-high reset
//   in_valid/in_ready             - operand handshake
//   in_multiplicand/in_multiplier - operands A, B
//   dp_init, dp_shift             - datapath load / iterate strobes
//   dp_multiplicand/dp_multiplier - registered operands to datapath
//   dp_hi, dp_lo                  - datapath result registers
//   out_valid/out_ready           - product handshake
//   out_product                   - captured {HI,LO}
//   busy                          - any state other than IDLE
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_multiplicand,
   input  logic [WIDTH-1:0]   in_multiplier,
   output logic               dp_init,
   output logic               dp_shift,
   output logic [WIDTH-1:0]   dp_multiplicand,
   output logic [WIDTH-1:0]   dp_multiplier,
   input  logic [WIDTH-1:0]   dp_hi,
   input  logic [WIDTH-1:0]   dp_lo,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);

   state_t state;
   logic   cnt_last;
   logic   accept;

   iter_counter #(.WIDTH(WIDTH)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .clear  (state == LOAD),
      .enable (state == RUN),
      .last   (cnt_last)
   );

   // In HOLD a new pair can be taken in the same cycle the product is
   // consumed, giving back-to-back operation without an IDLE bubble.
   assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept    = in_valid && in_ready;

   assign dp_init   = (state == LOAD);
   assign dp_shift  = (state == RUN);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         dp_multiplicand <= '0;
         dp_multiplier   <= '0;
         out_product     <= '0;
      end else begin
         if (accept) begin
            dp_multiplicand <= in_multiplicand;
            dp_multiplier   <= in_multiplier;
         end
         case (state)
            IDLE:    if (in_valid) state <= LOAD;
            LOAD:    state <= RUN;
            RUN:     if (cnt_last) state <= CAPTURE;
            CAPTURE: begin
               // datapath registers hold the final result one cycle after
               // the last shift pulse
               out_product <= {dp_hi, dp_lo};
               state       <= HOLD;
            end
            HOLD:    if (out_ready) state <= in_valid ? LOAD : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

   logic       clock = 0;
   logic       reset = 1;
   logic       in_valid = 0;
   logic       in_ready;
   logic [3:0] in_multiplicand = 0;
   logic [3:0] in_multiplier = 0;
   logic       dp_init, dp_shift;
   logic [3:0] dp_multiplicand, dp_multiplier;
   logic [3:0] dp_hi, dp_lo;
   logic       out_valid;
   logic       out_ready = 0;
   logic [7:0] out_product;
   logic       busy;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   mult_sequencer dut (
      .clock           (clock),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_multiplicand (in_multiplicand),
      .in_multiplier   (in_multiplier),
      .dp_init         (dp_init),
      .dp_shift        (dp_shift),
      .dp_multiplicand (dp_multiplicand),
      .dp_multiplier   (dp_multiplier),
      .dp_hi           (dp_hi),
      .dp_lo           (dp_lo),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_product     (out_product),
      .busy            (busy)
   );

   // behavioural shift-add datapath
   logic [3:0] m_hi, m_lo, m_m;
   logic [4:0] m_sum;
   assign m_sum = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_m} : 5'd0);
   assign dp_hi = m_hi;
   assign dp_lo = m_lo;

   always @(posedge clock) begin
      if (dp_init) begin
         m_hi <= 4'd0;
         m_lo <= dp_multiplier;
         m_m  <= dp_multiplicand;
      end else if (dp_shift) begin
         m_hi <= m_sum[4:1];
         m_lo <= {m_sum[0], m_lo[3:1]};
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue one op from IDLE, consume it when valid, return to IDLE
   task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
      in_valid = 1; in_multiplicand = a; in_multiplier = b;
      #1;
      chk({tag, "_rdy"}, in_ready, 1);
      tick();                       // T+1
      in_valid = 0;
      chk({tag, "_init"}, dp_init, 1);
      repeat (5) tick();            // T+6
      chk({tag, "_cap_nv"}, out_valid, 0);
      tick();                       // T+7
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_prod"}, out_product, exp);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk({tag, "_idle"}, busy, 0);
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] e;
   logic       acc;
   int         n_sent, n_got, inits, shifts;

   initial begin
      // reset state
      tick(); tick();
      reset = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_init", dp_init, 0);
      chk("rst_shift", dp_shift, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prod", out_product, 0);
      chk("rst_mcand", dp_multiplicand, 0);
      chk("rst_mplier", dp_multiplier, 0);

      // 3x5 with exact cycle timing, then backpressure
      in_valid = 1; in_multiplicand = 4'd3; in_multiplier = 4'd5;
      #1;
      chk("t0_rdy", in_ready, 1);
      tick();                                   // T+1
      in_valid = 0;
      chk("t1_init", dp_init, 1);
      chk("t1_shift", dp_shift, 0);
      chk("t1_rdy", in_ready, 0);
      chk("t1_mcand", dp_multiplicand, 3);
      chk("t1_mplier", dp_multiplier, 5);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("t%0d_init", k), dp_init, 0);
         chk($sformatf("t%0d_shift", k), dp_shift, 1);
         chk($sformatf("t%0d_rdy", k), in_ready, 0);
      end
      tick();                                   // T+6 capture
      chk("t6_shift", dp_shift, 0);
      chk("t6_ov", out_valid, 0);
      chk("t6_rdy", in_ready, 0);
      tick();                                   // T+7
      chk("t7_ov", out_valid, 1);
      chk("t7_prod", out_product, 8'h0F);

      in_valid = 1; in_multiplicand = 4'd2; in_multiplier = 4'd4;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_rdy", in_ready, 0);
         tick();
         chk("bp_ov", out_valid, 1);
         chk("bp_prod", out_product, 8'h0F);
         chk("bp_init", dp_init, 0);
      end
      out_ready = 1;
      #1;
      chk("b2b_rdy", in_ready, 1);
      tick();                                   // LOAD of 2x4
      out_ready = 0; in_valid = 0;
      chk("b2b_init", dp_init, 1);
      chk("b2b_ov", out_valid, 0);
      chk("b2b_mcand", dp_multiplicand, 2);
      repeat (5) tick();
      chk("b2b_t6_ov", out_valid, 0);
      tick();
      chk("b2b_ov2", out_valid, 1);
      chk("b2b_prod", out_product, 8'h08);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("b2b_idle", busy, 0);

      do_op("m15x15", 4'd15, 4'd15, 8'hE1);
      do_op("m0x9", 4'd0, 4'd9, 8'h00);
      do_op("m9x0", 4'd9, 4'd0, 8'h00);

      // reset in the second RUN cycle of 7x6
      in_valid = 1; in_multiplicand = 4'd7; in_multiplier = 4'd6;
      tick();                                   // T+1 LOAD
      in_valid = 0;
      tick();                                   // T+2 RUN
      tick();                                   // T+3 second RUN
      chk("ab_shift_pre", dp_shift, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("ab_busy", busy, 0);
      chk("ab_ov", out_valid, 0);
      chk("ab_shift", dp_shift, 0);
      chk("ab_init", dp_init, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("ab_no_prod", out_valid, 0);
      end
      do_op("m7x6", 4'd7, 4'd6, 8'h2A);

      // random traffic
      n_sent = 0; n_got = 0; inits = 0; shifts = 0;
      for (int c = 0; c < 20000 && n_got < 200; c++) begin
         if (dp_init) inits++;
         if (dp_shift) shifts++;
         if (!in_valid && n_sent < 200 && $urandom_range(0, 2) != 0) begin
            in_valid = 1;
            in_multiplicand = 4'($urandom);
            in_multiplier = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("rnd_dup", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rnd_prod", out_product, e);
            end
            chk("rnd_inits", inits, 1);
            chk("rnd_shifts", shifts, 4);
            inits = 0; shifts = 0;
            n_got++;
         end
         if (acc) begin
            exp_q.push_back(8'(in_multiplicand) * 8'(in_multiplier));
            n_sent++;
         end
         tick();
         if (acc) in_valid = 0;
      end
      out_ready = 0;
      in_valid = 0;
      chk("rnd_count", n_got, 200);
      chk("rnd_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
